// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host state encoding, keyboard command bytes and parity helper
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, RECOVER} state_t;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizers for ps2Clk/ps2Dat plus falling-edge pulse on the clock
module ps2_sync_edge (
  input  logic iCLK,
  input  logic reset,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);
  logic [2:0] cq;
  logic [1:0] dq;
  always_ff @(posedge iCLK or negedge reset)
    if (!reset) begin
      cq <= 3'b111;
      dq <= 2'b11;
    end else begin
      cq <= {cq[1:0], clk_in};
      dq <= {dq[0], dat_in};
    end
  assign clk_s    = cq[1];
  assign dat_s    = dq[1];
  assign clk_fall = cq[2] & ~cq[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with ACK/NACK reporting.
// Define PS2_TX_WDOG_EN to add the TIMEOUT_CYC inter-edge watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 10800,
  parameter int TIMEOUT_CYC = 2160000
) (
  input  logic       iCLK,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  state_t state, state_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [3:0] ecnt, ecnt_n;
  logic [8:0] frame, frame_n;
  logic done_n, err_n, clk_s, dat_s, clk_fall, wdog_hit, inh_last;
  ps2_sync_edge u_sync (
    .iCLK    (iCLK),
    .reset   (reset),
    .clk_in  (ps2_clk_in),
    .dat_in  (ps2_dat_in),
    .clk_s   (clk_s),
    .dat_s   (dat_s),
    .clk_fall(clk_fall)
  );
`ifdef PS2_TX_WDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wcnt;
  logic wait_dev;
  assign wait_dev = state inside {START, SHIFT, ACK};
  // wcnt equals the number of cycles elapsed since the last device falling edge
  always_ff @(posedge iCLK or negedge reset)
    if (!reset) wcnt <= '0;
    else wcnt <= (clk_fall || !wait_dev) ? WW'(1) : wcnt + 1'b1;
  assign wdog_hit = wait_dev && !clk_fall && wcnt == WW'(TIMEOUT_CYC - 1);
`else
  assign wdog_hit = TIMEOUT_CYC < 0;
`endif
  assign inh_last   = icnt == IW'(INHIBIT_CYC - 1);
  assign ps2_clk_oe = state == INHIBIT;
  assign ps2_dat_oe = (state == INHIBIT && inh_last) || state == START ||
                      (state == SHIFT && !frame[ecnt - 4'd1]);
  assign tx_busy    = state != IDLE;
  always_comb begin
    state_n = state;
    icnt_n  = icnt;
    ecnt_n  = ecnt;
    frame_n = frame;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (wdog_hit) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end else
      case (state)
        IDLE: if (tx_start) begin
          frame_n = {odd_par(tx_data), tx_data};
          icnt_n  = '0;
          ecnt_n  = '0;
          state_n = INHIBIT;
        end
        INHIBIT: begin
          icnt_n  = inh_last ? icnt : icnt + 1'b1;
          state_n = inh_last ? START : INHIBIT;
        end
        START: if (clk_fall) begin
          ecnt_n  = 4'd1;
          state_n = SHIFT;
        end
        SHIFT: if (clk_fall) begin
          ecnt_n  = ecnt + 4'd1;
          state_n = ecnt == 4'd9 ? ACK : SHIFT;
        end
        ACK: if (clk_fall) begin
          done_n  = ~dat_s;
          err_n   = dat_s;
          state_n = RECOVER;
        end
        RECOVER: state_n = (clk_s && dat_s) ? IDLE : RECOVER;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge iCLK or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      icnt    <= '0;
      ecnt    <= '0;
      frame   <= '0;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
    end else begin
      state   <= state_n;
      icnt    <= icnt_n;
      ecnt    <= ecnt_n;
      frame   <= frame_n;
      tx_done <= done_n;
      tx_err  <= err_n;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a behavioural PS/2 device driving an open-collector bus
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 10800, TMO = 1000, HALF = 10, SYNC_LAT = 2;
  typedef struct {bit err; bit chk; logic [7:0] data;} exp_t;
  logic iCLK = 1'b0, reset = 1'b0, tx_start = 1'b0, dev_clk = 1'b1, dev_dat = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_err;
  // each line is low when either side pulls it
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;
  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .iCLK(iCLK), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );
  always #5 iCLK = ~iCLK;
  int cyc = 0, fall_cyc = 0, tests = 0, fails = 0;
  always @(posedge iCLK) cyc++;
  exp_t q[$];
  logic [7:0] rx_byte = 8'h00;
  logic rx_par = 1'b0, rx_stop = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic ref_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction
  always @(negedge iCLK)
    if (reset && (tx_done || tx_err)) begin
      if (q.size() == 0) check("unexpected_pulse", {tx_done, tx_err}, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("done_err_excl", tx_done & tx_err, 0);
        check("result_err", tx_err, e.err);
        if (e.chk) begin
          check("rx_byte", rx_byte, e.data);
          check("rx_parity", rx_par, ref_par(e.data));
          check("rx_stop", rx_stop, 1);
        end
      end
    end
  task automatic run_frame(input logic [7:0] b, input logic ack, input int nf, input bit poke);
    int n, d;
    logic [11:0] bits;
    bits = '0;
    @(negedge iCLK);
    tx_data = b;
    tx_start = 1'b1;
    if (nf == 11) q.push_back('{ack, 1'b1, b});
    @(negedge iCLK);
    tx_start = 1'b0;
    tx_data = 8'($urandom);
    check("busy_after_start", tx_busy, 1);
    n = 0;
    d = 0;
    while (ps2_clk_oe && n < INH + 10) begin
      n++;
      d += int'(ps2_dat_oe);
      @(negedge iCLK);
    end
    check("inhibit_len", n, INH);
    check("inhibit_dat_cycles", d, 1);
    check("start_bit_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
    for (int i = 1; i <= nf; i++) begin
      if (i == 11) begin
        rx_byte = bits[8:1];
        rx_par  = bits[9];
        rx_stop = bits[10];
        dev_dat = ack;
      end
      repeat (3) @(negedge iCLK);
      dev_clk = 1'b0;
      fall_cyc = cyc;
      if (poke && i == 5) begin
        @(negedge iCLK);
        tx_data = 8'($urandom);
        tx_start = 1'b1;
        @(negedge iCLK);
        tx_start = 1'b0;
        repeat (HALF - 2) @(negedge iCLK);
      end else repeat (HALF) @(negedge iCLK);
      bits[i] = ps2_dat_in;
      if (i == 11) check("recover_holds", tx_busy, 1);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge iCLK);
      dev_dat = 1'b1;
    end
  endtask
  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while (tx_busy && n < lim) begin
      n++;
      @(negedge iCLK);
    end
    check(name, tx_busy, 0);
    check({name, "_drained"}, q.size(), 0);
  endtask
  initial begin
    #1200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    logic [7:0] b;
    int n;
    repeat (3) @(negedge iCLK);
    check("reset_outs", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_err}, 0);
    reset = 1'b1;
    @(negedge iCLK);
    check("idle_outs", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_err}, 0);
    run_frame(CMD_SET_LED, 1'b0, 11, 1'b0);
    wait_idle("idle_set_led", 100);
    run_frame(8'h00, 1'b0, 11, 1'b0);
    wait_idle("idle_00", 100);
    run_frame(8'h01, 1'b0, 11, 1'b0);
    wait_idle("idle_01", 100);
    run_frame(8'($urandom), 1'b1, 11, 1'b0);
    wait_idle("idle_nack", 100);
    run_frame(8'($urandom), 1'b0, 4, 1'b0);
`ifdef PS2_TX_WDOG_EN
    q.push_back('{1'b1, 1'b0, 8'h00});
    n = 0;
    while (!tx_err && n < TMO + 100) begin
      n++;
      @(negedge iCLK);
    end
    check("wdog_latency", cyc - fall_cyc, TMO + SYNC_LAT);
    check("wdog_release", {ps2_clk_oe, ps2_dat_oe}, 0);
    wait_idle("idle_wdog", 10);
`else
    repeat (TMO + 50) @(negedge iCLK);
    check("no_wdog_busy", tx_busy, 1);
    reset = 1'b0;
    @(negedge iCLK);
    reset = 1'b1;
`endif
    b = 8'($urandom) & 8'hDF;
    run_frame(b, 1'b0, 6, 1'b0);
    check("pre_reset_dat_oe", ps2_dat_oe, 1);
    reset = 1'b0;
    #1;
    check("reset_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("reset_mid_busy", tx_busy, 0);
    repeat (5) @(negedge iCLK);
    reset = 1'b1;
    repeat (5) @(negedge iCLK);
    run_frame(CMD_ENABLE, 1'b0, 11, 1'b1);
    wait_idle("idle_enable", 100);
    repeat (20) @(negedge iCLK);
    check("final_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
